// File: rtl/bresen_pkg.sv
// Shared types and default geometry for the Bresenham line generator.
package bresen_pkg;

  localparam int DEF_XW       = 10;
  localparam int DEF_YW       = 9;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ADDR_W   = 19;

  function automatic int err_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int DEF_EW = err_width(DEF_XW, DEF_YW);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_t;

  typedef logic signed [DEF_EW-1:0] err_t;

endpackage

// File: rtl/bresen_line_gen_if.sv
// Command and pixel-stream bundle of the line generator.
interface bresen_line_gen_if #(
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int ADDR_W = 19
);
  logic                     start;
  logic [2*(XW+YW)-1:0]     positions;
  logic                     busy;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [ADDR_W-1:0]        pix_addr;
  logic [XW-1:0]            pix_x;
  logic [YW-1:0]            pix_y;
  logic                     line_done;

  modport master (
    output start, positions, pix_ready,
    input  busy, pix_valid, pix_addr,
    input  pix_x, pix_y, line_done
  );

  modport slave (
    input  start, positions, pix_ready,
    output busy, pix_valid, pix_addr,
    output pix_x, pix_y, line_done
  );
endinterface

// File: rtl/bresen_addr.sv
// Linear framebuffer address y*SCREEN_W+x, truncated to ADDR_W.
module bresen_addr #(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int SCREEN_W = 640,
  parameter int ADDR_W   = 19
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] xa, ya;

  assign xa = ADDR_W'(x);
  assign ya = ADDR_W'(y);

  generate
    if (SCREEN_W == 640) begin : g_shift
      // 640 = 512 + 128, so no multiplier is needed
      assign addr = (ya << 9) + (ya << 7) + xa;
    end else begin : g_mul
      assign addr = ya * ADDR_W'(SCREEN_W) + xa;
    end
  endgenerate
endmodule

// File: rtl/bresen_line_gen.sv
// Bresenham line rasteriser streaming pixels over a valid/ready handshake.
// Define BRESEN_CLIP_EN to silently skip off-screen pixels.
module bresen_line_gen
  import bresen_pkg::*;
#(
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input logic clk,
  input logic rst,
  bresen_line_gen_if.slave bus
);
  localparam int PW = 2 * (XW + YW);
  localparam int EW = err_width(XW, YW);

  state_t state, nxt;

  logic [PW-1:0]        pos;
  logic [XW-1:0]        x, px0, px1;
  logic [YW-1:0]        y, py0, py1;
  logic signed [EW-1:0] dx, dy, err;
  logic signed [EW-1:0] e2, nerr;
  logic signed [EW-1:0] ddx, ddy, sdx, sdy;
  logic                 xneg, yneg;
  logic                 at_end, off, adv;

  assign px0 = pos[PW-1 -: XW];
  assign py0 = pos[PW-XW-1 -: YW];
  assign px1 = pos[XW+YW-1 -: XW];
  assign py1 = pos[YW-1:0];

  assign ddx = $signed(EW'(px1)) - $signed(EW'(px0));
  assign ddy = $signed(EW'(py1)) - $signed(EW'(py0));
  assign sdx = ddx[EW-1] ? -ddx : ddx;
  assign sdy = ddy[EW-1] ? ddy : -ddy;

  assign at_end = (x == px1) && (y == py1);

`ifdef BRESEN_CLIP_EN
  assign off = (int'(x) >= SCREEN_W) || (int'(y) >= SCREEN_H);
`else
  logic unused_cfg;
  assign unused_cfg = (SCREEN_H == 0);
  assign off = 1'b0;
`endif

  // Off-screen pixels step one per cycle regardless of the consumer
  assign adv           = (state == DRAW) && (bus.pix_ready || off);
  assign bus.pix_valid = (state == DRAW) && !off;
  assign bus.busy      = (state != IDLE);
  assign bus.line_done = (state == DONE);
  assign bus.pix_x     = x;
  assign bus.pix_y     = y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus.start) nxt = SETUP;
      SETUP: nxt = DRAW;
      DRAW:  if (adv && at_end) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Both tests use the pre-step error term
  always_comb begin
    e2   = err <<< 1;
    nerr = err;
    if (e2 >= dy) nerr = nerr + dy;
    if (e2 <= dx) nerr = nerr + dx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      x    <= '0;
      y    <= '0;
      dx   <= '0;
      dy   <= '0;
      err  <= '0;
      xneg <= 1'b0;
      yneg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) pos <= bus.positions;
        SETUP: begin
          x    <= px0;
          y    <= py0;
          dx   <= sdx;
          dy   <= sdy;
          err  <= sdx + sdy;
          xneg <= (px1 < px0);
          yneg <= (py1 < py0);
        end
        DRAW: if (adv && !at_end) begin
          err <= nerr;
          if (e2 >= dy) x <= xneg ? x - XW'(1) : x + XW'(1);
          if (e2 <= dx) y <= yneg ? y - YW'(1) : y + YW'(1);
        end
        default: ;
      endcase
    end
  end

  bresen_addr #(
    .XW       (XW),
    .YW       (YW),
    .SCREEN_W (SCREEN_W),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .x    (x),
    .y    (y),
    .addr (bus.pix_addr)
  );
endmodule

// File: tb/tb_bresen_line_gen.sv
// Directed self-checking bench for bresen_line_gen.
module tb_bresen_line_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  int q_addr[$];
  int q_x[$];
  int q_y[$];
  int q_cyc[$];
  int done_cyc;
  int end_cyc;

  always #5 clk = ~clk;

  bresen_line_gen_if #(.XW(10), .YW(9), .ADDR_W(19)) bus ();

  bresen_line_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [37:0] mkpos(input int x0, input int y0,
                                        input int x1, input int y1);
    return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
  endfunction

  task automatic kick(input logic [37:0] p);
    @(negedge clk);
    bus.positions = p;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Cycle 0 is the negedge two edges after start was sampled
  task automatic collect(input int budget);
    q_addr.delete(); q_x.delete(); q_y.delete(); q_cyc.delete();
    done_cyc = -1;
    end_cyc  = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) begin
        q_addr.push_back(int'(bus.pix_addr));
        q_x.push_back(int'(bus.pix_x));
        q_y.push_back(int'(bus.pix_y));
        q_cyc.push_back(c);
      end
      if (bus.line_done && done_cyc < 0) done_cyc = c;
      if (!bus.busy) begin
        end_cyc = c;
        break;
      end
    end
    vecs++;
    if (end_cyc < 0) begin
      errs++;
      $display("FAIL timeout: busy still %0b after %0d cycles", bus.busy, budget);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.positions = '0; bus.pix_ready = 1'b1;
    #1;
    vecs++;
    if ({bus.busy, bus.pix_valid, bus.line_done} !== 3'b000 ||
        bus.pix_addr !== 19'd0) begin
      errs++;
      $display("FAIL reset: busy/valid/done=%b%b%b addr=%0d, want 000 addr 0",
               bus.busy, bus.pix_valid, bus.line_done, bus.pix_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    int exp_a[4] = '{0, 1, 2, 3};
    kick(mkpos(0, 0, 3, 0));
    vecs++;
    if (bus.busy !== 1'b1 || bus.pix_valid !== 1'b0) begin
      errs++;
      $display("FAIL horiz_setup: busy=%b valid=%b, want 1 0", bus.busy, bus.pix_valid);
    end
    collect(20);
    vecs++;
    if (q_addr.size() != 4 || q_cyc[0] != 0) begin
      errs++;
      $display("FAIL horiz_count: got %0d pixels first at %0d, want 4 at 0",
               q_addr.size(), (q_cyc.size() > 0) ? q_cyc[0] : -1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (q_addr[i] != exp_a[i] || q_cyc[i] != i) begin
          errs++;
          $display("FAIL horiz_pix%0d: addr %0d cyc %0d, want addr %0d cyc %0d",
                   i, q_addr[i], q_cyc[i], exp_a[i], i);
        end
      end
    end
    vecs++;
    if (done_cyc != 4 || end_cyc != 5) begin
      errs++;
      $display("FAIL horiz_done: line_done at %0d idle at %0d, want 4 and 5",
               done_cyc, end_cyc);
    end
  endtask

  task automatic test_steep();
    int ea[5] = '{2562, 1921, 1281, 640, 0};
    int ex[5] = '{2, 1, 1, 0, 0};
    int ey[5] = '{4, 3, 2, 1, 0};
    kick(mkpos(2, 4, 0, 0));
    collect(20);
    vecs++;
    if (q_addr.size() != 5) begin
      errs++;
      $display("FAIL steep_count: got %0d pixels, want 5", q_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vecs++;
        if (q_addr[i] != ea[i] || q_x[i] != ex[i] || q_y[i] != ey[i]) begin
          errs++;
          $display("FAIL steep_pix%0d: (%0d,%0d) addr %0d, want (%0d,%0d) addr %0d",
                   i, q_x[i], q_y[i], q_addr[i], ex[i], ey[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_point();
    kick(mkpos(5, 5, 5, 5));
    collect(10);
    vecs++;
    if (q_addr.size() != 1 || q_addr[0] != 3205 || done_cyc != 1 || end_cyc != 2) begin
      errs++;
      $display("FAIL point: %0d pixels addr %0d done %0d idle %0d, want 1 3205 1 2",
               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : -1, done_cyc, end_cyc);
    end
  endtask

  task automatic test_stall();
    int seen[$];
    int hold_bad = 0;
    int c = 0;
    kick(mkpos(0, 0, 3, 0));
    while (c < 30 && bus.busy) begin
      @(negedge clk);
      c++;
      if (bus.pix_valid && bus.pix_addr == 19'd1 && seen.size() == 1) begin
        bus.pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          c++;
          if (bus.pix_valid !== 1'b1 || bus.pix_addr !== 19'd1) hold_bad++;
        end
        bus.pix_ready = 1'b1;
      end
      if (bus.pix_valid && bus.pix_ready) seen.push_back(int'(bus.pix_addr));
    end
    bus.pix_ready = 1'b1;
    vecs++;
    if (hold_bad != 0) begin
      errs++;
      $display("FAIL stall_hold: %0d stalled cycles lost addr 1, want 0", hold_bad);
    end
    vecs++;
    if (seen.size() != 4 || seen[0] != 0 || seen[1] != 1 || seen[2] != 2 || seen[3] != 3) begin
      errs++;
      $display("FAIL stall_seq: %0d pixels, want 0,1,2,3", seen.size());
    end
  endtask

  task automatic test_worst();
    kick(mkpos(640, 0, 0, 480));
    collect(800);
`ifdef BRESEN_CLIP_EN
    vecs++;
    if (q_addr.size() < 1 || q_x[0] != 639 || q_y[0] != 1 || done_cyc < 0) begin
      errs++;
      $display("FAIL worst_clip: first (%0d,%0d) done %0d, want (639,1) and done",
               (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1, done_cyc);
    end
`else
    vecs++;
    if (q_addr.size() != 641 || q_addr[0] != 640 || q_addr[$] != 307200) begin
      errs++;
      $display("FAIL worst: %0d pixels first %0d last %0d, want 641 640 307200",
               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : -1,
               (q_addr.size() > 0) ? q_addr[$] : -1);
    end
    vecs++;
    if (done_cyc != 641) begin
      errs++;
      $display("FAIL worst_done: line_done at %0d, want 641", done_cyc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int stray = 0;
    int c = 0;
    kick(mkpos(640, 0, 0, 480));
    while (c < 100 && n < 10) begin
      @(negedge clk);
      c++;
      if (bus.pix_valid) n++;
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (n != 10 || bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.pix_addr !== 19'd0 || bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0) begin
      errs++;
      $display("FAIL reset_mid: n=%0d valid=%b busy=%b addr=%0d, want 10 0 0 0",
               n, bus.pix_valid, bus.busy, bus.pix_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.pix_valid || bus.line_done || bus.busy) stray++;
    end
    vecs++;
    if (stray != 0) begin
      errs++;
      $display("FAIL reset_quiet: %0d active cycles after reset, want 0", stray);
    end
    kick(mkpos(0, 0, 3, 0));
    collect(20);
    vecs++;
    if (q_addr.size() != 4 || q_addr[0] != 0 || q_addr[3] != 3 || done_cyc != 4) begin
      errs++;
      $display("FAIL reset_redraw: %0d pixels done %0d, want 4 pixels 0..3 done 4",
               q_addr.size(), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_point();
    test_stall();
    test_worst();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
